// File: rtl/mac_pkg.sv
// Shared types and width derivation for the mac_pipe_param multiply-add pipeline.
package mac_pkg;

    typedef enum logic {
        MODE_MADD = 1'b0,
        MODE_ACC  = 1'b1
    } mac_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } mac_state_t;

    function automatic int mac_out_w(input int data_w, input int acc_guard);
        return 2 * data_w + acc_guard;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Stage 1 of mac_pipe_param: full-width product plus sideband register bank, enabled by adv1.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    input  logic [DATA_W-1:0]     i_c,
    input  logic                  i_mode,
    input  logic                  i_last,
    output logic                  o_valid,
    output logic [2*DATA_W-1:0]   o_prod,
    output logic [DATA_W-1:0]     o_c,
    output logic                  o_mode,
    output logic                  o_last
);

    logic [2*DATA_W-1:0] w_prod;
    logic                r_valid;
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W-1:0]   r_c;
    logic                r_mode;
    logic                r_last;

    assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_prod  <= '0;
            r_c     <= '0;
            r_mode  <= MODE_MADD;
            r_last  <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_prod  <= w_prod;
            r_c     <= i_c;
            r_mode  <= i_mode;
            r_last  <= i_last;
        end
    end

    assign o_valid = r_valid;
    assign o_prod  = r_prod;
    assign o_c     = r_c;
    assign o_mode  = r_mode;
    assign o_last  = r_last;

endmodule

// File: rtl/mac_pipe_param.sv
// Two-stage unsigned multiply-add / burst-accumulate pipeline with valid/ready flow control.
// Define MAC_SAT_EN to clamp overflowing results and accumulators to all-ones instead of wrapping.
module mac_pipe_param
    import mac_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int ACC_GUARD = 4,
    localparam int OUT_W     = mac_out_w(DATA_W, ACC_GUARD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic              mode,
    input  logic              last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  data_out,
    output logic              ovf
);

    logic                w_adv1;
    logic                w_adv2;
    logic                w_s1_valid;
    logic [2*DATA_W-1:0] w_s1_prod;
    logic [DATA_W-1:0]   w_s1_c;
    logic                w_s1_mode;
    logic                w_s1_last;
    logic                w_acc_path;
    logic                w_emit;
    logic [OUT_W-1:0]    w_base;
    logic [OUT_W:0]      w_sum;
    logic                w_ovf;
    logic [OUT_W-1:0]    w_res;

    logic                r_out_valid;
    logic [OUT_W-1:0]    r_data_out;
    logic                r_ovf;
    logic [OUT_W-1:0]    r_acc;
    logic                r_acc_ovf;
    mac_state_t          r_state;

    assign w_adv2   = !r_out_valid || out_ready;
    assign w_adv1   = !w_s1_valid || w_adv2;
    assign in_ready = w_adv1 && !rst;

    mac_mult_stage #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_adv1),
        .i_valid (in_valid),
        .i_a     (a),
        .i_b     (b),
        .i_c     (c),
        .i_mode  (mode),
        .i_last  (last),
        .o_valid (w_s1_valid),
        .o_prod  (w_s1_prod),
        .o_c     (w_s1_c),
        .o_mode  (w_s1_mode),
        .o_last  (w_s1_last)
    );

    // Only an ACC beat continuing a burst adds onto the accumulator; MADD and burst-first beats use c.
    assign w_acc_path = (w_s1_mode == MODE_ACC) && (r_state == ST_BURST);
    assign w_emit     = (w_s1_mode == MODE_MADD) || w_s1_last;
    assign w_base     = w_acc_path ? r_acc : {{(OUT_W-DATA_W){1'b0}}, w_s1_c};
    assign w_sum      = {1'b0, w_base} + {{(OUT_W+1-2*DATA_W){1'b0}}, w_s1_prod};
    assign w_ovf      = w_sum[OUT_W] || (w_acc_path && r_acc_ovf);

`ifdef MAC_SAT_EN
    assign w_res = w_ovf ? '1 : w_sum[OUT_W-1:0];
`else
    assign w_res = w_sum[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
            r_state     <= ST_IDLE;
        end else if (w_adv2) begin
            if (w_s1_valid) begin
                if (w_s1_mode == MODE_ACC) begin
                    if (w_s1_last) begin
                        r_acc     <= '0;
                        r_acc_ovf <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_acc     <= w_res;
                        r_acc_ovf <= w_ovf;
                        r_state   <= ST_BURST;
                    end
                end
                r_out_valid <= w_emit;
                if (w_emit) begin
                    r_data_out <= w_res;
                    r_ovf      <= w_ovf;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign ovf       = r_ovf;

endmodule
